// File: rtl/dmem_responder.sv
// Data-memory responder for a CPU data port: accepts one request at a time,
// inserts WAIT_STATES wait cycles, then returns a one-cycle ready strobe.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        ready,
  output logic        fault
);

  // state  | meaning
  // S_IDLE | no request outstanding; accept a new one
  // S_WAIT | request latched, counting down wait cycles
  // S_RESP | ready strobe; writes commit at the end of this cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WS4 = WAIT_STATES[3:0];

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] lat_word;
  logic [3:0]            lat_strb;
  logic [31:0]           lat_data;
  logic                  lat_read;
  logic                  lat_fault;
  logic [31:0]           dout_r;

  logic       req;
  logic       strb_legal;
  logic [1:0] strb_low;
  logic       in_fault;

  logic [ADDR_WIDTH-1:0] cur_word;
  logic                  cur_read;
  logic                  cur_fault;
  logic                  enter_resp;

  assign req = data_read | (data_write != 4'b0000);

  always_comb begin
    strb_legal = 1'b0;
    case (data_write)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: strb_legal = 1'b1;
      default:                   strb_legal = 1'b0;
    endcase
  end

  always_comb begin
    strb_low = 2'd0;
    casez (data_write)
      4'b???1: strb_low = 2'd0;
      4'b??10: strb_low = 2'd1;
      4'b?100: strb_low = 2'd2;
      4'b1000: strb_low = 2'd3;
      default: strb_low = 2'd0;
    endcase
  end

  always_comb begin
    in_fault = 1'b0;
    if (data_read && (data_write != 4'b0000))
      in_fault = 1'b1;
    if (|data_addr[31:ADDR_WIDTH+2])
      in_fault = 1'b1;
    if ((data_write != 4'b0000) && (!strb_legal || (strb_low != data_addr[1:0])))
      in_fault = 1'b1;
    if (data_read && (data_addr[1:0] != 2'b00))
      in_fault = 1'b1;
  end

  // With zero wait states RESP is entered straight from IDLE, so the read
  // path must look at the live inputs rather than the latched copy.
  always_comb begin
    cur_word  = lat_word;
    cur_read  = lat_read;
    cur_fault = lat_fault;
    if (state == S_IDLE) begin
      cur_word  = data_addr[ADDR_WIDTH+1:2];
      cur_read  = data_read;
      cur_fault = in_fault;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS4 - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_word  <= '0;
      lat_strb  <= 4'd0;
      lat_data  <= 32'd0;
      lat_read  <= 1'b0;
      lat_fault <= 1'b0;
      dout_r    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        lat_word  <= data_addr[ADDR_WIDTH+1:2];
        lat_strb  <= data_write;
        lat_data  <= data_in;
        lat_read  <= data_read;
        lat_fault <= in_fault;
      end
      if (enter_resp && cur_read && !cur_fault)
        dout_r <= mem[cur_word];
      else
        dout_r <= 32'd0;
    end
  end

  // Array is deliberately not reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && !lat_read && !lat_fault) begin
      for (int k = 0; k < 4; k++) begin
        if (lat_strb[k])
          mem[lat_word][8*k +: 8] <= lat_data[8*k +: 8];
      end
    end
  end

  assign ready    = (state == S_RESP) && !rst;
  assign fault    = ready && lat_fault;
  assign data_out = ready ? dout_r : 32'd0;
  assign stall    = req && !rst && (state != S_RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed and random requests, checked against a word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        data_read_s  [2];
  logic [3:0]  data_write_s [2];
  logic [31:0] data_addr_s  [2];
  logic [31:0] data_in_s    [2];
  logic [31:0] data_out_s   [2];
  logic        stall_s      [2];
  logic        ready_s      [2];
  logic        fault_s      [2];

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst(rst),
    .data_read(data_read_s[0]), .data_write(data_write_s[0]),
    .data_addr(data_addr_s[0]), .data_in(data_in_s[0]),
    .data_out(data_out_s[0]), .stall(stall_s[0]),
    .ready(ready_s[0]), .fault(fault_s[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst),
    .data_read(data_read_s[1]), .data_write(data_write_s[1]),
    .data_addr(data_addr_s[1]), .data_in(data_in_s[1]),
    .data_out(data_out_s[1]), .stall(stall_s[1]),
    .ready(ready_s[1]), .fault(fault_s[1])
  );

  int checks = 0;
  int errors = 0;
  int ws_of [2] = '{2, 0};
  logic [31:0] mm [2][16];
  logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_fault(input bit rd, input logic [3:0] wr, input logic [31:0] a);
    bit ok;
    int lo;
    if (rd && wr != 0) return 1;
    if (a >= 32'd4096) return 1;
    if (rd) return a[1:0] != 2'd0;
    ok = 0;
    foreach (legal[i]) if (wr == legal[i]) ok = 1;
    if (!ok) return 1;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (wr[i]) lo = i;
    return lo != int'(a[1:0]);
  endfunction

  function automatic int lowest_lane(input logic [3:0] wr);
    for (int i = 0; i < 4; i++) if (wr[i]) return i;
    return 0;
  endfunction

  task automatic idle_inputs(input int d);
    data_read_s[d]  = 1'b0;
    data_write_s[d] = 4'd0;
    data_addr_s[d]  = 32'd0;
    data_in_s[d]    = 32'd0;
  endtask

  // Called just after a rising edge; returns just after the edge ending RESP.
  task automatic do_req(input int d, input bit rd, input logic [3:0] wr,
                        input logic [31:0] a, input logic [31:0] din,
                        input bit scramble, input string tag);
    bit ef;
    logic [31:0] exp_data;
    int ws;
    ws = ws_of[d];
    ef = exp_fault(rd, wr, a);
    exp_data = (rd && !ef) ? mm[d][a[5:2]] : 32'd0;
    data_read_s[d]  = rd;
    data_write_s[d] = wr;
    data_addr_s[d]  = a;
    data_in_s[d]    = din;
    for (int k = 0; k <= ws + 1; k++) begin
      if (scramble && k >= 1 && k <= ws) begin
        data_addr_s[d] = $urandom & 32'h0000_003C;
        data_in_s[d]   = $urandom;
      end
      #4;
      if (k <= ws) begin
        chk({tag, ".stall"}, {31'd0, stall_s[d]}, 32'd1);
        chk({tag, ".early_ready"}, {31'd0, ready_s[d]}, 32'd0);
      end else begin
        chk({tag, ".ready"}, {31'd0, ready_s[d]}, 32'd1);
        chk({tag, ".resp_stall"}, {31'd0, stall_s[d]}, 32'd0);
        chk({tag, ".fault"}, {31'd0, fault_s[d]}, {31'd0, ef});
        chk({tag, ".data_out"}, data_out_s[d], exp_data);
      end
      @(posedge clk); #1;
    end
    idle_inputs(d);
    if (!rd && !ef)
      for (int i = 0; i < 4; i++)
        if (wr[i]) mm[d][a[5:2]][8*i +: 8] = din[8*i +: 8];
  endtask

  initial begin
    logic [31:0] a, din;
    logic [3:0] wr;
    bit rd;
    int d, kind;

    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    data_read_s[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", {31'd0, stall_s[0]}, 32'd0);
    chk("rst.ready", {31'd0, ready_s[0]}, 32'd0);
    chk("rst.fault", {31'd0, fault_s[0]}, 32'd0);
    chk("rst.data_out", data_out_s[0], 32'd0);
    chk("rst.ready_ws0", {31'd0, ready_s[1]}, 32'd0);
    idle_inputs(0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int dd = 0; dd < 2; dd++)
      for (int w = 0; w < 16; w++)
        do_req(dd, 0, 4'hF, w * 4, $urandom, 0, "init");

    do_req(0, 0, 4'hF, 32'h10, 32'hDEADBEEF, 0, "wr_full");
    do_req(0, 1, 4'h0, 32'h10, 32'h0, 0, "rd_full");
    do_req(0, 0, 4'b0100, 32'h12, 32'h00AB0000, 0, "wr_byte");
    do_req(0, 1, 4'h0, 32'h10, 32'h0, 0, "rd_merged");
    chk("merge_model", mm[0][4], 32'hDEABBEEF);

    do_req(0, 0, 4'b0011, 32'h11, 32'h11111111, 0, "flt_align");
    do_req(0, 1, 4'h0, 32'h02, 32'h0, 0, "flt_rd_off");
    do_req(0, 1, 4'hF, 32'h10, 32'h22222222, 0, "flt_both");
    do_req(0, 1, 4'h0, 32'h1000, 32'h0, 0, "flt_range");
    do_req(0, 0, 4'b0101, 32'h10, 32'h33333333, 0, "flt_strb");
    do_req(0, 1, 4'h0, 32'h10, 32'h0, 0, "rd_after_flt");

    do_req(1, 0, 4'hF, 32'h10, 32'hA5A5_0F0F, 0, "ws0_wr");
    do_req(1, 1, 4'h0, 32'h10, 32'h0, 0, "ws0_b2b_a");
    do_req(1, 1, 4'h0, 32'h14, 32'h0, 0, "ws0_b2b_b");
    do_req(1, 0, 4'b1100, 32'h16, 32'h7777_0000, 0, "ws0_b2b_c");
    do_req(1, 1, 4'h0, 32'h14, 32'h0, 0, "ws0_b2b_d");

    do_req(0, 1, 4'h0, 32'h08, 32'h0, 1, "scr_rd");
    do_req(0, 0, 4'hF, 32'h0C, 32'h0BAD_CAFE, 1, "scr_wr");
    do_req(0, 1, 4'h0, 32'h0C, 32'h0, 0, "scr_rdback");

    // reset while the 2-wait-state instance is in WAIT
    data_write_s[0] = 4'hF;
    data_addr_s[0]  = 32'h20;
    data_in_s[0]    = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b1;
    #3 chk("rstwait.ready_in_rst", {31'd0, ready_s[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs(0);
    for (int k = 0; k < 4; k++) begin
      #3 chk("rstwait.no_ready", {31'd0, ready_s[0]}, 32'd0);
      @(posedge clk); #1;
    end
    do_req(0, 1, 4'h0, 32'h20, 32'h0, 0, "rstwait.rd");

    // reset during RESP of the zero-wait instance
    data_write_s[1] = 4'hF;
    data_addr_s[1]  = 32'h24;
    data_in_s[1]    = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    #3 chk("rstresp.no_ready", {31'd0, ready_s[1]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs(1);
    #3 chk("rstresp.idle_ready", {31'd0, ready_s[1]}, 32'd0);
    @(posedge clk); #1;
    do_req(1, 1, 4'h0, 32'h24, 32'h0, 0, "rstresp.rd");

    for (int n = 0; n < 120; n++) begin
      d = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      din = $urandom;
      if (kind <= 3) begin
        rd = 1; wr = 4'h0;
        if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(0, 3));
      end else begin
        rd = (kind == 9);
        wr = 4'($urandom_range(1, 15));
        a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(lowest_lane(wr));
      end
      if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      do_req(d, rd, wr, a, din, (d == 0) && ($urandom_range(0, 1) == 1), "rand");
    end

    for (int w = 0; w < 16; w++) begin
      do_req(0, 1, 4'h0, w * 4, 32'h0, 0, "final_ws2");
      do_req(1, 1, 4'h0, w * 4, 32'h0, 0, "final_ws0");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address width; array holds 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles inserted between request acceptance and response, range 0..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_read  input  1  read request from CPU data port.
REQ-006 data_write  input  4  byte-lane write strobes; bit k writes data_in[8k+7:8k].
REQ-007 data_addr  input  32  byte address.
REQ-008 data_in  input  32  write data, already lane-aligned.
REQ-009 data_out  output  32  read data, valid only while ready=1.
REQ-010 stall  output  1  combinational; requester holds request stable and does not advance while high.
REQ-011 ready  output  1  one-cycle response strobe.
REQ-012 fault  output  1  qualifies ready; request rejected.

Function
REQ-013 Request present (req) = data_read | (data_write != 0).
REQ-014 FSM states IDLE, WAIT, RESP; wait counter 4 bits.
REQ-015 IDLE: req=1 -> latch addr/strobes/data/kind; WAIT_STATES=0 -> RESP, else WAIT with counter=WAIT_STATES-1; req=0 -> stay IDLE.
REQ-016 WAIT: counter=0 -> RESP, else decrement; input changes during WAIT ignored (latched copy used).
REQ-017 RESP: ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Request accepted in cycle T gets ready in cycle T+1+WAIT_STATES.
REQ-019 stall = req & (state is IDLE or WAIT); stall=0 in RESP.
REQ-020 A req seen in IDLE the cycle after RESP is a new request; no back-to-back ready in adjacent cycles.
REQ-021 Fault conditions: data_read and data_write!=0 together; data_addr[31:ADDR_WIDTH+2] nonzero; strobes not in {0001,0010,0100,1000,0011,1100,1111}; lowest set strobe index != addr[1:0]; read with addr[1:0]!=0.
REQ-022 Fault evaluated at acceptance; faulting request follows normal timing, ready=1 and fault=1 in RESP, no array write, data_out=0.
REQ-023 Read: data_out = word at addr[ADDR_WIDTH+1:2], registered on entry to RESP.
REQ-024 Write: enabled lanes committed on the clock edge ending the RESP cycle; disabled lanes unchanged; data_out=0.
REQ-025 Read in the request following a write to the same word returns merged new data.
REQ-026 fault=0 and data_out=0 whenever ready=0.

Reset
REQ-027 rst=1: state IDLE, counter 0, ready=0, fault=0, data_out=0, stall=0, latched request cleared.
REQ-028 rst mid-request (WAIT or RESP): request dropped, no write committed, no ready issued.
REQ-029 Array contents not cleared by reset.

Verification
REQ-030 WAIT_STATES=2: write 0xDEADBEEF, strobes 1111, addr 0x10 at T -> stall high T..T+2, ready T+3, fault 0; read 0x10 later -> data_out 0xDEADBEEF.
REQ-031 Byte merge: word 0x10=0xDEADBEEF, write data_in 0x00AB0000, strobes 0100, addr 0x12 -> read returns 0xDEABBEEF.
REQ-032 Faults: strobes 0011 with addr 0x11; read addr 0x02; read+write together; addr 0x1000 with ADDR_WIDTH=10 -> each ready with fault=1, data_out 0, array unchanged.
REQ-033 WAIT_STATES=0: read at T -> stall high T only, ready T+1; back-to-back requests -> ready every second cycle.
REQ-034 rst asserted in WAIT of write 0x12345678 to addr 0x20 -> no ready; subsequent read 0x20 returns prior contents.
REQ-035 Inputs changed during WAIT -> response reflects values latched at acceptance.
